// File: rtl/sd_host_regbank.sv
// SD host register bank: host bus decode, hardware/host merge, W1C status, command start and irq.
// Optional: define SD_REGBANK_IRQ_EN to enable the 0x38 signal-enable register and the irq output.
module sd_host_regbank #(
    parameter int unsigned ADDR_W      = 13,
    parameter int unsigned ADMA_ADDR_W = 64,
    parameter int unsigned RESP_WORDS  = 4
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    wr_en,
    input  logic                    rd_en,
    input  logic [ADDR_W-1:0]       addrs,
    input  logic [3:0]              byte_en,
    input  logic [31:0]             wr_data,
    output logic [31:0]             rd_data,
    output logic                    rd_valid,
    input  logic [31:0]             psr_hw,
    input  logic [31:0]             psr_hw_en,
    input  logic [15:0]             nisr_set,
    input  logic [15:0]             eisr_set,
    input  logic [32*RESP_WORDS-1:0] resp_hw,
    input  logic [RESP_WORDS-1:0]   resp_hw_en,
    input  logic                    bcr_dec,
    output logic [11:0]             blk_size,
    output logic [15:0]             blk_count,
    output logic [31:0]             argument,
    output logic [15:0]             xfer_mode,
    output logic [15:0]             command,
    output logic [15:0]             bgcr,
    output logic [ADMA_ADDR_W-1:0]  adma_addr,
    output logic                    start_flag,
    output logic                    irq
);

    localparam int unsigned WW = ADDR_W - 2;

    logic [WW-1:0] word;
    logic [31:0]   be_mask;

    logic [11:0] blk_size_q, blk_size_d;
    logic [15:0] blk_count_q, blk_count_d;
    logic [31:0] argument_q, argument_d;
    logic [15:0] xfer_mode_q, xfer_mode_d;
    logic [15:0] command_q, command_d;
    logic [15:0] bgcr_q, bgcr_d;
    logic [31:0] psr_q, psr_d;
    logic [31:0] status_q, status_d, status_rd;
    logic [31:0] status_en_q, status_en_d;
    logic [31:0] adma_lo_q, adma_lo_d;
    logic [31:0] adma_hi_q, adma_hi_d;
    logic [31:0] resp_q [RESP_WORDS];
    logic [31:0] rd_data_q, rd_mux;
    logic        rd_valid_q;
    logic        start_q;

    logic [31:0] bsr_new, cmd_new, w1c, set_raw;
    logic        cmd_wr_hi, cmd_accept, cmd_err;
    logic        sel_bsr, sel_arg, sel_cmd, sel_bgcr, sel_sts, sel_sten, sel_adlo, sel_adhi;

    assign word    = addrs[ADDR_W-1:2];
    assign be_mask = {{8{byte_en[3]}}, {8{byte_en[2]}}, {8{byte_en[1]}}, {8{byte_en[0]}}};

    assign sel_bsr  = (word == WW'(1));
    assign sel_arg  = (word == WW'(2));
    assign sel_cmd  = (word == WW'(3));
    assign sel_bgcr = (word == WW'(10));
    assign sel_sts  = (word == WW'(12));
    assign sel_sten = (word == WW'(13));
    assign sel_adlo = (word == WW'(22));
    assign sel_adhi = (word == WW'(23)) && (ADMA_ADDR_W > 32);

    // NISR[15] is a live summary of EISR, never stored.
    assign status_rd = {status_q[31:16], |status_q[31:16], status_q[14:0]};

    assign cmd_wr_hi  = wr_en && sel_cmd && (byte_en[3:2] != 2'b00);
    assign cmd_accept = cmd_wr_hi && !psr_q[0];
    assign cmd_err    = cmd_wr_hi && psr_q[0];

`ifdef SD_REGBANK_IRQ_EN
    logic [31:0] sig_en_q, sig_en_d;
    logic        irq_q;
    logic        sel_sgen;
    assign sel_sgen = (word == WW'(14));
`endif

    always_comb begin
        bsr_new = ({blk_count_q, 4'b0, blk_size_q} & ~be_mask) | (wr_data & be_mask);
        cmd_new = ({command_q, xfer_mode_q} & ~be_mask) | (wr_data & be_mask);

        blk_size_d = blk_size_q;
        blk_count_d = blk_count_q;
        if (wr_en && sel_bsr) begin
            blk_size_d = bsr_new[11:0];
        end
        // A host write to the count lanes overrides the engine's decrement.
        if (wr_en && sel_bsr && (byte_en[3:2] != 2'b00)) begin
            blk_count_d = bsr_new[31:16];
        end else if (bcr_dec && (blk_count_q != 16'h0)) begin
            blk_count_d = blk_count_q - 16'h1;
        end

        argument_d = argument_q;
        if (wr_en && sel_arg) begin
            argument_d = (argument_q & ~be_mask) | (wr_data & be_mask);
        end

        xfer_mode_d = xfer_mode_q;
        command_d   = command_q;
        if (wr_en && sel_cmd) begin
            xfer_mode_d = cmd_new[15:0];
        end
        if (cmd_accept) begin
            command_d = cmd_new[31:16];
        end

        bgcr_d = bgcr_q;
        if (wr_en && sel_bgcr) begin
            bgcr_d = (bgcr_q & ~be_mask[31:16]) | (wr_data[31:16] & be_mask[31:16]);
        end

        psr_d = (psr_q & ~psr_hw_en) | (psr_hw & psr_hw_en);

        w1c      = (wr_en && sel_sts) ? (wr_data & be_mask) : 32'h0;
        set_raw  = {eisr_set, nisr_set} | {7'b0, cmd_err, 24'b0};
        status_d = ((status_q & ~w1c) | (set_raw & status_en_q)) & ~32'h0000_8000;

        status_en_d = status_en_q;
        if (wr_en && sel_sten) begin
            status_en_d = (status_en_q & ~be_mask) | (wr_data & be_mask);
        end

        adma_lo_d = adma_lo_q;
        adma_hi_d = adma_hi_q;
        if (wr_en && sel_adlo) begin
            adma_lo_d = (adma_lo_q & ~be_mask) | (wr_data & be_mask);
        end
        if (wr_en && sel_adhi) begin
            adma_hi_d = (adma_hi_q & ~be_mask) | (wr_data & be_mask);
        end

`ifdef SD_REGBANK_IRQ_EN
        sig_en_d = sig_en_q;
        if (wr_en && sel_sgen) begin
            sig_en_d = (sig_en_q & ~be_mask) | (wr_data & be_mask);
        end
`endif
    end

    always_comb begin
        rd_mux = 32'h0;
        if (sel_bsr)  rd_mux = {blk_count_q, 4'b0, blk_size_q};
        if (sel_arg)  rd_mux = argument_q;
        if (sel_cmd)  rd_mux = {command_q, xfer_mode_q};
        if (word == WW'(9)) rd_mux = psr_q;
        if (sel_bgcr) rd_mux = {bgcr_q, 16'h0};
        if (sel_sts)  rd_mux = status_rd;
        if (sel_sten) rd_mux = status_en_q;
        if (sel_adlo) rd_mux = adma_lo_q;
        if (sel_adhi) rd_mux = adma_hi_q;
`ifdef SD_REGBANK_IRQ_EN
        if (sel_sgen) rd_mux = sig_en_q;
`endif
        for (int i = 0; i < int'(RESP_WORDS); i++) begin
            if (word == WW'(4 + i)) rd_mux = resp_q[i];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            blk_size_q  <= '0;
            blk_count_q <= '0;
            argument_q  <= '0;
            xfer_mode_q <= '0;
            command_q   <= '0;
            bgcr_q      <= '0;
            psr_q       <= '0;
            status_q    <= '0;
            status_en_q <= '0;
            adma_lo_q   <= '0;
            adma_hi_q   <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            start_q     <= 1'b0;
            for (int i = 0; i < int'(RESP_WORDS); i++) resp_q[i] <= '0;
        end else begin
            blk_size_q  <= blk_size_d;
            blk_count_q <= blk_count_d;
            argument_q  <= argument_d;
            xfer_mode_q <= xfer_mode_d;
            command_q   <= command_d;
            bgcr_q      <= bgcr_d;
            psr_q       <= psr_d;
            status_q    <= status_d;
            status_en_q <= status_en_d;
            adma_lo_q   <= adma_lo_d;
            adma_hi_q   <= adma_hi_d;
            rd_valid_q  <= rd_en;
            start_q     <= cmd_accept;
            if (rd_en) rd_data_q <= rd_mux;
            for (int i = 0; i < int'(RESP_WORDS); i++) begin
                if (resp_hw_en[i]) resp_q[i] <= resp_hw[32*i +: 32];
            end
        end
    end

`ifdef SD_REGBANK_IRQ_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sig_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            sig_en_q <= sig_en_d;
            irq_q    <= |(status_rd & sig_en_q);
        end
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    generate
        if (ADMA_ADDR_W > 32) begin : g_adma64
            assign adma_addr = {adma_hi_q[ADMA_ADDR_W-33:0], adma_lo_q};
        end else begin : g_adma32
            assign adma_addr = adma_lo_q[ADMA_ADDR_W-1:0];
        end
    endgenerate

    logic unused_bits;
    assign unused_bits = ^{addrs[1:0], bsr_new[15:12], adma_hi_q};

    assign blk_size   = blk_size_q;
    assign blk_count  = blk_count_q;
    assign argument   = argument_q;
    assign xfer_mode  = xfer_mode_q;
    assign command    = command_q;
    assign bgcr       = bgcr_q;
    assign start_flag = start_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_sd_host_regbank.sv
// Directed bench for sd_host_regbank; inputs change on the falling edge, outputs sampled there too.
module tb_sd_host_regbank;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         wr_en, rd_en;
    logic [12:0]  addrs;
    logic [3:0]   byte_en;
    logic [31:0]  wr_data, rd_data;
    logic         rd_valid;
    logic [31:0]  psr_hw, psr_hw_en;
    logic [15:0]  nisr_set, eisr_set;
    logic [127:0] resp_hw;
    logic [3:0]   resp_hw_en;
    logic         bcr_dec;
    logic [11:0]  blk_size;
    logic [15:0]  blk_count, xfer_mode, command, bgcr;
    logic [31:0]  argument;
    logic [63:0]  adma_addr;
    logic         start_flag, irq;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] rd;

    always #5 CLK = ~CLK;

    sd_host_regbank dut (
        .CLK(CLK), .RESET(RESET), .wr_en(wr_en), .rd_en(rd_en), .addrs(addrs),
        .byte_en(byte_en), .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid),
        .psr_hw(psr_hw), .psr_hw_en(psr_hw_en), .nisr_set(nisr_set), .eisr_set(eisr_set),
        .resp_hw(resp_hw), .resp_hw_en(resp_hw_en), .bcr_dec(bcr_dec),
        .blk_size(blk_size), .blk_count(blk_count), .argument(argument),
        .xfer_mode(xfer_mode), .command(command), .bgcr(bgcr), .adma_addr(adma_addr),
        .start_flag(start_flag), .irq(irq)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic bus_write(input logic [12:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge CLK);
        wr_en = 1'b1; addrs = a; wr_data = d; byte_en = be;
        @(negedge CLK);
        wr_en = 1'b0; byte_en = 4'h0;
    endtask

    task automatic bus_read(input logic [12:0] a, output logic [31:0] d);
        @(negedge CLK);
        rd_en = 1'b1; addrs = a;
        @(negedge CLK);
        rd_en = 1'b0;
        check("rd_valid", 64'(rd_valid), 64'h1);
        d = rd_data;
    endtask

    task automatic dec_pulse(input logic [15:0] exp);
        @(negedge CLK);
        bcr_dec = 1'b1;
        @(negedge CLK);
        bcr_dec = 1'b0;
        check("blk_count_dec", 64'(blk_count), 64'(exp));
    endtask

    initial begin
        RESET = 1'b1; wr_en = 0; rd_en = 0; addrs = 0; byte_en = 0; wr_data = 0;
        psr_hw = 0; psr_hw_en = 0; nisr_set = 0; eisr_set = 0; resp_hw = 0; resp_hw_en = 0;
        bcr_dec = 0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        check("rst_start", 64'(start_flag), 64'h0);
        check("rst_irq", 64'(irq), 64'h0);
        check("rst_rd_valid", 64'(rd_valid), 64'h0);

        bus_read(13'h04, rd); check("rd_04", 64'(rd), 64'h0);
        bus_read(13'h24, rd); check("rd_24", 64'(rd), 64'h0);
        bus_read(13'h30, rd); check("rd_30", 64'(rd), 64'h0);
        @(negedge CLK);
        check("rd_valid_drop", 64'(rd_valid), 64'h0);

        // Accepted command write
        bus_write(13'h0C, 32'h0D1A_0020, 4'hF);
        check("start_pulse", 64'(start_flag), 64'h1);
        check("command", 64'(command), 64'h0D1A);
        check("xfer_mode", 64'(xfer_mode), 64'h0020);
        @(negedge CLK);
        check("start_one_cycle", 64'(start_flag), 64'h0);

        // Back-to-back accepted writes
        @(negedge CLK);
        wr_en = 1'b1; addrs = 13'h0C; byte_en = 4'hF; wr_data = 32'h0C01_0001;
        @(negedge CLK);
        wr_data = 32'h0C02_0002;
        check("b2b_start0", 64'(start_flag), 64'h1);
        @(negedge CLK);
        wr_en = 1'b0; byte_en = 4'h0;
        check("b2b_start1", 64'(start_flag), 64'h1);
        @(negedge CLK);
        check("b2b_start_end", 64'(start_flag), 64'h0);
        check("b2b_command", 64'(command), 64'h0C02);

        // Gated command while cmd_inhibit
        bus_write(13'h34, 32'h0100_0003, 4'hF);
        @(negedge CLK);
        psr_hw = 32'h1; psr_hw_en = 32'h1;
        @(negedge CLK);
        psr_hw_en = 32'h0;
        bus_read(13'h24, rd); check("psr", 64'(rd), 64'h1);
        bus_write(13'h24, 32'hFFFF_FFFF, 4'hF);
        bus_read(13'h24, rd); check("psr_ro", 64'(rd), 64'h1);
        bus_write(13'h0C, 32'h1100_0000, 4'hF);
        check("gated_start", 64'(start_flag), 64'h0);
        check("gated_command", 64'(command), 64'h0C02);
        check("gated_xfer", 64'(xfer_mode), 64'h0000);
        @(negedge CLK);
        nisr_set = 16'h0004;   // bit 2 not enabled
        @(negedge CLK);
        nisr_set = 16'h0;
        bus_read(13'h30, rd); check("cmd_err_sts", 64'(rd), 64'h0100_8000);
        bus_write(13'h30, 32'h0100_0000, 4'hF);
        bus_read(13'h30, rd); check("sts_cleared", 64'(rd), 64'h0);
        @(negedge CLK);
        psr_hw = 32'h0; psr_hw_en = 32'h1;
        @(negedge CLK);
        psr_hw_en = 32'h0;

        // Hardware set beats host clear
        @(negedge CLK);
        nisr_set = 16'h0001; wr_en = 1'b1; addrs = 13'h30; wr_data = 32'h1; byte_en = 4'hF;
        @(negedge CLK);
        nisr_set = 16'h0; wr_en = 1'b0; byte_en = 4'h0;
        bus_read(13'h30, rd); check("set_wins", 64'(rd), 64'h1);
        bus_write(13'h30, 32'h1, 4'hF);
        bus_read(13'h30, rd); check("w1c", 64'(rd), 64'h0);

        // Block count
        bus_write(13'h04, 32'h0002_0200, 4'hF);
        check("blk_size", 64'(blk_size), 64'h200);
        check("blk_count", 64'(blk_count), 64'h2);
        dec_pulse(16'h1);
        dec_pulse(16'h0);
        dec_pulse(16'h0);
        @(negedge CLK);
        bcr_dec = 1'b1; wr_en = 1'b1; addrs = 13'h04; wr_data = 32'h0005_0200; byte_en = 4'hF;
        @(negedge CLK);
        bcr_dec = 1'b0; wr_en = 1'b0; byte_en = 4'h0;
        check("write_beats_dec", 64'(blk_count), 64'h5);

        // Byte lanes
        bus_write(13'h08, 32'hAABB_CCDD, 4'hF);
        bus_write(13'h08, 32'h1122_3344, 4'b0101);
        check("byte_lanes", 64'(argument), 64'hAA22_CC44);
        bus_write(13'h28, 32'h1234_5678, 4'hF);
        check("bgcr", 64'(bgcr), 64'h1234);

        // Responses
        @(negedge CLK);
        resp_hw = {32'h0, 32'h0, 32'hCAFE_F00D, 32'h0}; resp_hw_en = 4'b0010;
        @(negedge CLK);
        resp_hw_en = 4'b0;
        bus_write(13'h14, 32'h0, 4'hF);
        bus_read(13'h14, rd); check("resp1", 64'(rd), 64'hCAFE_F00D);

        bus_write(13'h40, 32'hFFFF_FFFF, 4'hF);
        bus_read(13'h40, rd); check("unmapped", 64'(rd), 64'h0);

        bus_write(13'h58, 32'h1234_5678, 4'hF);
        bus_write(13'h5C, 32'h9ABC_DEF0, 4'hF);
        check("adma_addr", adma_addr, 64'h9ABC_DEF0_1234_5678);

        // Interrupt
        bus_write(13'h38, 32'h2, 4'hF);
        @(negedge CLK);
        nisr_set = 16'h0002;
        @(negedge CLK);
        nisr_set = 16'h0;
`ifdef SD_REGBANK_IRQ_EN
        bus_read(13'h38, rd); check("sig_en", 64'(rd), 64'h2);
        check("irq_set", 64'(irq), 64'h1);
        bus_write(13'h30, 32'h2, 4'hF);
        @(negedge CLK);
        check("irq_clear", 64'(irq), 64'h0);
`else
        @(negedge CLK);
        check("irq_off", 64'(irq), 64'h0);
        bus_read(13'h38, rd); check("sig_en_off", 64'(rd), 64'h0);
`endif

        // Reset during an access
        @(negedge CLK);
        RESET = 1'b1; wr_en = 1'b1; rd_en = 1'b1; addrs = 13'h08;
        wr_data = 32'hDEAD_BEEF; byte_en = 4'hF;
        @(negedge CLK);
        RESET = 1'b0; wr_en = 1'b0; rd_en = 1'b0; byte_en = 4'h0;
        check("abort_rd_valid", 64'(rd_valid), 64'h0);
        check("abort_argument", 64'(argument), 64'h0);
        check("abort_blk_count", 64'(blk_count), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
